// File: rtl/score_panel_pkg.sv
// score_panel_pkg: shared types and constants for the HUD score panel.
//   state_e      - conversion sequencer states
//   ASCII_*      - character codes for digits and blank cells
//   LABEL_ROM    - four left-justified 16-character field labels, 0x00 padded
//   label_char() - fetch one label character by field index and column
package score_panel_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StStore,
        StCommit
    } state_e;

    localparam logic [6:0]  ASCII_ZERO  = 7'h30;
    localparam logic [6:0]  ASCII_BLANK = 7'h00;
    localparam int unsigned LABEL_LEN   = 16;
    localparam int unsigned MAX_FIELDS  = 4;
    localparam int unsigned MAX_DIGITS  = 10;

    // Entry [0] is the last element of the concatenation.
    localparam logic [MAX_FIELDS-1:0][8*LABEL_LEN-1:0] LABEL_ROM = {
        {"LEVEL:",     80'h0},
        {"LIVES:",     80'h0},
        {"SCORE REQ:", 48'h0},
        {"SCORE:",     80'h0}
    };

    // Column 0 is the leftmost (most significant) byte of the label word.
    function automatic logic [6:0] label_char(input logic [1:0] idx, input logic [3:0] col);
        logic [8*LABEL_LEN-1:0] w_s;
        w_s = LABEL_ROM[idx];
        return w_s[8*(LABEL_LEN-1-col) +: 7];
    endfunction

endpackage

// File: rtl/bcd_dabble_seq.sv
// bcd_dabble_seq: one-field iterative double-dabble converter.
//   i_clk, i_rst - clock, synchronous active-high reset
//   i_start      - load i_bin, clear BCD and overflow; shifting follows for BIN_W cycles
//   i_bin        - binary value to convert
//   o_bcd        - BCD result, DIGITS nibbles, LSD in [3:0]
//   o_ovf        - sticky: a 1 was shifted out of the top nibble
//   o_ready      - high on the cycle whose clock edge performs the final shift
module bcd_dabble_seq #(
    parameter int unsigned DIGITS = 6,
    parameter int unsigned BIN_W  = 24
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [BIN_W-1:0]      i_bin,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_ovf,
    output logic                  o_ready
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0]    r_bin;
    logic [4*DIGITS-1:0] r_bcd;
    logic                r_ovf;
    logic [CNT_W-1:0]    r_cnt;
    logic [4*DIGITS-1:0] w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_bin <= i_bin;
            r_bcd <= '0;
            r_ovf <= 1'b0;
            r_cnt <= CNT_W'(BIN_W);
        end else if (r_cnt != '0) begin
            r_bcd <= {w_adj[4*DIGITS-2:0], r_bin[BIN_W-1]};
            r_bin <= r_bin << 1;
            if (w_adj[4*DIGITS-1]) begin
                r_ovf <= 1'b1;
            end
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_bcd   = r_bcd;
    assign o_ovf   = r_ovf;
    assign o_ready = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/score_panel.sv
// score_panel: character-cell text generator for up to four labelled decimal fields.
//   i_clk, i_rst - clock, synchronous active-high reset
//   i_char_xy    - cell address, [7:4] row, [3:0] column
//   i_values     - packed binary field values, field f at [f*BIN_W +: BIN_W]
//   i_update     - snapshot i_values and convert; requests while busy collapse into one
//   o_char_code  - registered 7-bit ASCII code for the previous cycle's address
//   o_busy       - conversion in progress
//   o_done       - one-cycle pulse on the cycle the new digits are committed
// Build option: define SCORE_PANEL_LZB_EN for leading-zero blanking of digit cells.
module score_panel
    import score_panel_pkg::*;
#(
    parameter int unsigned NUM_FIELDS = 2,
    parameter int unsigned DIGITS     = 6,
    parameter int unsigned BIN_W      = 24
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [7:0]                  i_char_xy,
    input  logic [NUM_FIELDS*BIN_W-1:0] i_values,
    input  logic                        i_update,
    output logic [6:0]                  o_char_code,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam int unsigned BCD_W           = 4 * DIGITS;
    localparam int unsigned SNAP_W          = MAX_FIELDS * BIN_W;
    localparam logic [BCD_W-1:0] NINES      = {DIGITS{4'h9}};
    localparam logic [1:0] LAST_FIELD       = 2'(NUM_FIELDS - 1);
    localparam logic [3:0] FIRST_DIGIT_COL  = 4'(16 - DIGITS);

    state_e             r_state;
    logic [1:0]         r_field;
    logic               r_pending;
    logic               r_busy;
    logic               r_done;
    logic [SNAP_W-1:0]  r_snap;
    logic [BCD_W-1:0]   r_stage [MAX_FIELDS];
    logic [BCD_W-1:0]   r_disp  [MAX_FIELDS];
    logic [6:0]         r_char_code;

    logic               w_start;
    logic               w_ready;
    logic               w_ovf;
    logic [BCD_W-1:0]   w_bcd;
    logic [BIN_W-1:0]   w_bin;

    assign w_start = (r_state == StLoad);
    assign w_bin   = r_snap[int'(r_field)*BIN_W +: BIN_W];

    bcd_dabble_seq #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) u_dabble (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (w_start),
        .i_bin   (w_bin),
        .o_bcd   (w_bcd),
        .o_ovf   (w_ovf),
        .o_ready (w_ready)
    );

    // Sequencer: fields are converted into the staging bank one by one, then the
    // whole bank is copied to the display bank in a single cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_field   <= '0;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_snap    <= '0;
            for (int i = 0; i < int'(MAX_FIELDS); i++) begin
                r_stage[i] <= '0;
                r_disp[i]  <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_update) begin
                        r_snap  <= SNAP_W'(i_values);
                        r_field <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StLoad;
                    end
                end
                StLoad: r_state <= StShift;
                StShift: begin
                    if (w_ready) begin
                        r_state <= StStore;
                    end
                end
                StStore: begin
                    r_stage[r_field] <= w_ovf ? NINES : w_bcd;
                    if (r_field == LAST_FIELD) begin
                        r_done  <= 1'b1;
                        r_state <= StCommit;
                    end else begin
                        r_field <= r_field + 2'd1;
                        r_state <= StLoad;
                    end
                end
                StCommit: begin
                    r_disp <= r_stage;
                    // An update arriving on this very cycle restarts just like a pending one.
                    if (r_pending || i_update) begin
                        r_pending <= 1'b0;
                        r_snap    <= SNAP_W'(i_values);
                        r_field   <= '0;
                        r_state   <= StLoad;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
            if (i_update && (r_state inside {StLoad, StShift, StStore})) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Cell lookup
    logic [3:0]       w_row;
    logic [3:0]       w_col;
    logic [3:0]       w_pos;
    logic [3:0]       w_nib;
    logic [BCD_W-1:0] w_word;
    logic [6:0]       w_code;
`ifdef SCORE_PANEL_LZB_EN
    logic             w_upper_nz;
`endif

    assign w_row = i_char_xy[7:4];
    assign w_col = i_char_xy[3:0];
    assign w_pos = 4'd15 - w_col;  // digit weight: 0 is the LSD at column 15

    always_comb begin
        w_word = r_disp[w_row[1:0]];
        w_nib  = 4'h0;
        for (int p = 0; p < int'(DIGITS); p++) begin
            if (4'(p) == w_pos) begin
                w_nib = w_word[4*p +: 4];
            end
        end
`ifdef SCORE_PANEL_LZB_EN
        // Set when this digit or any more significant one is non-zero.
        w_upper_nz = 1'b0;
        for (int p = 0; p < int'(DIGITS); p++) begin
            if (4'(p) >= w_pos && w_word[4*p +: 4] != 4'h0) begin
                w_upper_nz = 1'b1;
            end
        end
`endif
        w_code = ASCII_BLANK;
        if (w_row < 4'(NUM_FIELDS)) begin
            if (w_col < FIRST_DIGIT_COL) begin
                w_code = label_char(w_row[1:0], w_col);
            end else begin
                w_code = ASCII_ZERO + {3'b000, w_nib};
`ifdef SCORE_PANEL_LZB_EN
                if (w_pos != 4'd0 && !w_upper_nz) begin
                    w_code = ASCII_BLANK;
                end
`endif
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_char_code <= '0;
        end else begin
            r_char_code <= w_code;
        end
    end

    assign o_char_code = r_char_code;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule
